vram_arbiter: RTL and testbench

Shares one VRAM memory port between two requesters. Port A is the CPU path, typically a WriteBuffer's bus side. Port B is the video scan-out fetch path of a video mode block. Video (B) has fixed priority because scan-out is deadline-bound. A starvation counter guarantees the CPU a slot after a bounded number of consecutive video grants. The block sits between the video-mode peripherals and a single-ported VRAM/SDRAM controller.

---
 rtl/vram_arbiter_pkg.sv | 5 +
 rtl/vram_arbiter.sv | 107 ++++++++++
 tb/tb_vram_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared FSM state type and counter width for the VRAM arbiter
package vram_arbiter_pkg;
  localparam int VRAM_ARB_CNT_W = 8;
  typedef enum logic [2:0] {IDLE, GRANT_A, GRANT_B, RELEASE_A, RELEASE_B} vram_arb_state_t;
endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between CPU (A) and video scan-out (B), B priority with CPU starvation guard
//   i_clock, i_reset        clock, asynchronous active-high reset
//   i_pa_* / o_pa_*         CPU port: request, rw, address, wdata in; rdata, ready out
//   i_pb_* / o_pb_*         video fetch port, same shape as A
//   o_bus_* / i_bus_*       single memory port toward the VRAM/SDRAM controller
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pa_request,
  input  logic        i_pa_rw,
  input  logic [31:0] i_pa_address,
  input  logic [31:0] i_pa_wdata,
  output logic [31:0] o_pa_rdata,
  output logic        o_pa_ready,
  input  logic        i_pb_request,
  input  logic        i_pb_rw,
  input  logic [31:0] i_pb_address,
  input  logic [31:0] i_pb_wdata,
  output logic [31:0] o_pb_rdata,
  output logic        o_pb_ready,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready
);
  localparam logic [VRAM_ARB_CNT_W-1:0] LIMIT = VRAM_ARB_CNT_W'(STARVE_LIMIT);
  vram_arb_state_t r_state, w_state;
  logic [VRAM_ARB_CNT_W-1:0] r_cnt, w_cnt;
  logic r_bus_request, w_bus_request, r_bus_rw, w_bus_rw;
  logic r_pa_ready, w_pa_ready, r_pb_ready, w_pb_ready;
  logic [31:0] r_bus_address, w_bus_address, r_bus_wdata, w_bus_wdata;
  logic [31:0] r_pa_rdata, w_pa_rdata, r_pb_rdata, w_pb_rdata;
  logic w_pick_b;
  // video wins unless the CPU is waiting and has already sat out LIMIT video grants
  assign w_pick_b = i_pb_request && (!i_pa_request || r_cnt < LIMIT);
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_bus_request = r_bus_request;
    w_bus_rw      = r_bus_rw;
    w_bus_address = r_bus_address;
    w_bus_wdata   = r_bus_wdata;
    w_pa_rdata    = r_pa_rdata;
    w_pb_rdata    = r_pb_rdata;
    w_pa_ready    = 1'b0;
    w_pb_ready    = 1'b0;
    case (r_state)
      IDLE: if (w_pick_b || i_pa_request) begin
        w_state       = w_pick_b ? GRANT_B : GRANT_A;
        w_bus_request = 1'b1;
        w_bus_rw      = w_pick_b ? i_pb_rw : i_pa_rw;
        w_bus_address = w_pick_b ? i_pb_address : i_pa_address;
        w_bus_wdata   = w_pick_b ? i_pb_wdata : i_pa_wdata;
        // counter tracks how long a pending CPU request has been passed over; saturates at all-ones
        w_cnt         = !w_pick_b ? '0 : (i_pa_request && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
      end
      GRANT_A, GRANT_B: if (i_bus_ready) begin
        w_state       = (r_state == GRANT_B) ? RELEASE_B : RELEASE_A;
        w_bus_request = 1'b0;
        w_pa_ready    = r_state == GRANT_A;
        w_pb_ready    = r_state == GRANT_B;
        w_pa_rdata    = (r_state == GRANT_A && !r_bus_rw) ? i_bus_rdata : r_pa_rdata;
        w_pb_rdata    = (r_state == GRANT_B && !r_bus_rw) ? i_bus_rdata : r_pb_rdata;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_bus_request <= 1'b0;
      r_bus_rw      <= 1'b0;
      r_bus_address <= '0;
      r_bus_wdata   <= '0;
      r_pa_rdata    <= '0;
      r_pb_rdata    <= '0;
      r_pa_ready    <= 1'b0;
      r_pb_ready    <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_bus_request <= w_bus_request;
      r_bus_rw      <= w_bus_rw;
      r_bus_address <= w_bus_address;
      r_bus_wdata   <= w_bus_wdata;
      r_pa_rdata    <= w_pa_rdata;
      r_pb_rdata    <= w_pb_rdata;
      r_pa_ready    <= w_pa_ready;
      r_pb_ready    <= w_pb_ready;
    end
  end
  assign o_bus_request = r_bus_request;
  assign o_bus_rw      = r_bus_rw;
  assign o_bus_address = r_bus_address;
  assign o_bus_wdata   = r_bus_wdata;
  assign o_pa_rdata    = r_pa_rdata;
  assign o_pb_rdata    = r_pb_rdata;
  assign o_pa_ready    = r_pa_ready;
  assign o_pb_ready    = r_pb_ready;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with directed scenarios and randomized traffic
module tb_vram_arbiter;
  localparam int LIM = 2;
  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tx_t;
  typedef struct {
    int          port;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  logic i_pa_request, i_pa_rw, i_pb_request, i_pb_rw;
  logic [31:0] i_pa_address, i_pa_wdata, i_pb_address, i_pb_wdata;
  logic [31:0] o_pa_rdata, o_pb_rdata, o_bus_address, o_bus_wdata;
  logic o_pa_ready, o_pb_ready, o_bus_request, o_bus_rw;
  logic [31:0] i_bus_rdata = '0;
  logic i_bus_ready = 1'b0;
  int vectors = 0, errors = 0, cyc = 0;
  tx_t  cur[2], drv[2];
  logic req_on[2], granted[2];
  int   gap[2], done[2], raise_cyc[2], grant_cyc[2];
  logic [31:0] mrd[2], hold[2];
  tx_t  txq_a[$], txq_b[$];
  exp_t expq[$];
  int   gseq[$];
  int   mcnt = 0, gport = 0, lat = 0, lat_lo = 0, lat_hi = 0, gap_max = 0, stray_en = 0, rdata_fix = 0;
  logic mem_pend = 1'b0, bus_prev = 1'b0;
  logic [31:0] rdata_val = '0;
  assign i_pa_request = req_on[0];
  assign i_pa_rw      = drv[0].rw;
  assign i_pa_address = drv[0].addr;
  assign i_pa_wdata   = drv[0].wdata;
  assign i_pb_request = req_on[1];
  assign i_pb_rw      = drv[1].rw;
  assign i_pb_address = drv[1].addr;
  assign i_pb_wdata   = drv[1].wdata;
  vram_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_pa_request(i_pa_request), .i_pa_rw(i_pa_rw), .i_pa_address(i_pa_address), .i_pa_wdata(i_pa_wdata),
    .o_pa_rdata(o_pa_rdata), .o_pa_ready(o_pa_ready),
    .i_pb_request(i_pb_request), .i_pb_rw(i_pb_rw), .i_pb_address(i_pb_address), .i_pb_wdata(i_pb_wdata),
    .o_pb_rdata(o_pb_rdata), .o_pb_ready(o_pb_ready),
    .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw), .o_bus_address(o_bus_address), .o_bus_wdata(o_bus_wdata),
    .i_bus_rdata(i_bus_rdata), .i_bus_ready(i_bus_ready)
  );
  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_bus_request"}, 32'(o_bus_request), 0);
    chk({tag, "_bus_rw"}, 32'(o_bus_rw), 0);
    chk({tag, "_bus_address"}, o_bus_address, 0);
    chk({tag, "_bus_wdata"}, o_bus_wdata, 0);
    chk({tag, "_pa_rdata"}, o_pa_rdata, 0);
    chk({tag, "_pb_rdata"}, o_pb_rdata, 0);
    chk({tag, "_pa_ready"}, 32'(o_pa_ready), 0);
    chk({tag, "_pb_ready"}, 32'(o_pb_ready), 0);
  endtask
  // one bench cycle: predict/verify grants, play the memory, play both requesters
  task automatic step();
    int p;
    logic a, b;
    @(posedge i_clock);
    #1;
    a = req_on[0];
    b = req_on[1];
    if (o_bus_request && !bus_prev) begin
      if (!a && !b) chk("grant_without_request", 1, 0);
      else begin
        p = (b && (!a || mcnt < LIM)) ? 1 : 0;
        mcnt = (p == 0) ? 0 : (a && mcnt < 255) ? mcnt + 1 : mcnt;
        gseq.push_back(p);
        chk("grant_rw", 32'(o_bus_rw), 32'(cur[p].rw));
        chk("grant_address", o_bus_address, cur[p].addr);
        chk("grant_wdata", o_bus_wdata, cur[p].wdata);
        granted[p] = 1'b1;
        grant_cyc[p] = cyc;
        gport = p;
        mem_pend = 1'b1;
        lat = $urandom_range(lat_hi, lat_lo);
      end
    end
    bus_prev = o_bus_request;
    if (i_bus_ready) i_bus_ready = 1'b0;
    else if (mem_pend) begin
      if (lat == 0) begin
        chk("frozen_address", o_bus_address, cur[gport].addr);
        chk("frozen_rw", 32'(o_bus_rw), 32'(cur[gport].rw));
        i_bus_ready = 1'b1;
        i_bus_rdata = rdata_fix ? rdata_val : $urandom;
        mem_pend = 1'b0;
        if (!cur[gport].rw) mrd[gport] = i_bus_rdata;
        expq.push_back('{gport, mrd[gport], cyc + 1});
      end else lat--;
    end else if (!o_bus_request && stray_en != 0 && $urandom_range(5, 0) == 0) begin
      i_bus_ready = 1'b1;
      i_bus_rdata = $urandom;
    end
    for (int q = 0; q < 2; q++) begin
      if (req_on[q]) begin
        if ((q == 1) ? o_pb_ready : o_pa_ready) begin
          req_on[q] = 1'b0;
          granted[q] = 1'b0;
          gap[q] = $urandom_range(gap_max, 0);
          done[q]++;
        end else if (granted[q]) begin
          drv[q].rw = 1'($urandom);
          drv[q].addr = $urandom;
          drv[q].wdata = $urandom;
        end
      end else if (gap[q] > 0) gap[q]--;
      else if (((q == 1) ? txq_b.size() : txq_a.size()) > 0) begin
        cur[q] = (q == 1) ? txq_b.pop_front() : txq_a.pop_front();
        drv[q] = cur[q];
        req_on[q] = 1'b1;
        raise_cyc[q] = cyc;
      end
    end
  endtask
  task automatic run(input int na, input int nb);
    int t = 0;
    done[0] = 0;
    done[1] = 0;
    while ((done[0] < na || done[1] < nb) && t < 3000) begin
      step();
      t++;
    end
    chk("completed_a", done[0], na);
    chk("completed_b", done[1], nb);
    repeat (3) step();
  endtask
  // monitor: every ready pulse must match the oldest expected completion, rdata must hold between pulses
  initial forever begin
    exp_t e;
    @(posedge i_clock);
    #1;
    if (i_reset) begin
      hold[0] = '0;
      hold[1] = '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if ((p == 1) ? o_pb_ready : o_pa_ready) begin
          if (expq.size() == 0) chk("unexpected_ready", 32'(p), 32'hFFFF_FFFF);
          else begin
            e = expq.pop_front();
            chk("ready_port", p, e.port);
            chk("ready_latency", cyc, e.due);
            hold[e.port] = e.rdata;
          end
        end
      end
      chk("pa_rdata", o_pa_rdata, hold[0]);
      chk("pb_rdata", o_pb_rdata, hold[1]);
    end
  end
  initial begin
    for (int p = 0; p < 2; p++) begin
      drv[p] = '{1'b0, 32'h0, 32'h0};
      cur[p] = drv[p];
      req_on[p] = 1'b0;
      granted[p] = 1'b0;
      gap[p] = 0;
      mrd[p] = '0;
      hold[p] = '0;
    end
    #1;
    check_zero("por");
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    lat_lo = 1;
    lat_hi = 1;
    txq_a.push_back('{1'b1, 32'h100, 32'hDEADBEEF});
    run(1, 0);
    chk("a_grant_latency", grant_cyc[0] - raise_cyc[0], 1);
    rdata_fix = 1;
    rdata_val = 32'h12345678;
    txq_b.push_back('{1'b0, 32'h400, 32'h0});
    run(0, 1);
    chk("pb_read_held", o_pb_rdata, 32'h12345678);
    chk("pa_rdata_untouched", o_pa_rdata, 32'h0);
    rdata_fix = 0;
    gseq.delete();
    txq_a.push_back('{1'b0, 32'h10, 32'h0});
    txq_b.push_back('{1'b0, 32'h20, 32'h0});
    run(1, 1);
    chk("simul_first_b", gseq.size() > 0 ? gseq[0] : -1, 1);
    chk("simul_second_a", gseq.size() > 1 ? gseq[1] : -1, 0);
    gseq.delete();
    repeat (2) txq_a.push_back('{1'b1, $urandom, $urandom});
    repeat (4) txq_b.push_back('{1'b0, $urandom, 32'h0});
    run(2, 4);
    for (int i = 0; i < 6; i++) chk("starve_order", i < gseq.size() ? gseq[i] : -1, (i % 3 == 2) ? 0 : 1);
    i_bus_ready = 1'b1;
    i_bus_rdata = 32'hBAD0BAD0;
    repeat (3) step();
    chk("stray_no_grant", 32'(o_bus_request), 0);
    lat_lo = 6;
    lat_hi = 6;
    txq_b.push_back('{1'b0, 32'h800, 32'h0});
    for (int t = 0; t < 20 && !(mem_pend && gport == 1); t++) step();
    chk("reached_grant_b", 32'(mem_pend && gport == 1), 1);
    #2;
    i_reset = 1'b1;
    #1;
    check_zero("async_reset");
    req_on[0] = 1'b0;
    req_on[1] = 1'b0;
    granted[0] = 1'b0;
    granted[1] = 1'b0;
    mem_pend = 1'b0;
    bus_prev = 1'b0;
    mcnt = 0;
    mrd[0] = '0;
    mrd[1] = '0;
    repeat (2) @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    lat_lo = 2;
    lat_hi = 0;
    txq_a.push_back('{1'b0, 32'h44, 32'h0});
    run(1, 0);
    lat_lo = 3;
    gap_max = 3;
    stray_en = 1;
    for (int i = 0; i < 40; i++) begin
      txq_a.push_back('{1'($urandom), $urandom, $urandom});
      txq_b.push_back('{1'($urandom), $urandom, $urandom});
    end
    run(40, 40);
    chk("scoreboard_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
